// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with a valid/ready handshake and a
// 2-entry skid buffer. Also provides a synchronous flush and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DATA_W     = 64,
    parameter int CTRL_W     = 8,
    parameter int CNT_W      = 16,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic              m_valid_reg, m_valid_next;
    logic [DATA_W-1:0] m_data_reg,  m_data_next;
    logic [CTRL_W-1:0] m_ctrl_reg,  m_ctrl_next;
    logic              s_valid_reg, s_valid_next;
    logic [DATA_W-1:0] s_data_reg,  s_data_next;
    logic [CTRL_W-1:0] s_ctrl_reg,  s_ctrl_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

    logic in_fire;
    logic out_fire;

    // in_ready depends only on stored state, so there is no path from out_ready.
    assign in_ready  = !s_valid_reg;
    assign in_fire   = in_valid && !s_valid_reg;
    assign out_fire  = m_valid_reg && out_ready;

    assign out_valid = m_valid_reg;
    assign out_data  = m_data_reg;
    assign out_ctrl  = m_valid_reg ? m_ctrl_reg : '0;
    assign stall_cnt = stall_cnt_reg;

    always_comb begin
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        m_ctrl_next  = m_ctrl_reg;
        s_valid_next = s_valid_reg;
        s_data_next  = s_data_reg;
        s_ctrl_next  = s_ctrl_reg;

        if (flush) begin
            m_valid_next = 1'b0;
            s_valid_next = 1'b0;
            if (CLEAR_DATA != 0) begin
                s_data_next = '0;
            end
        end else if (s_valid_reg && out_fire) begin
            m_data_next  = s_data_reg;
            m_ctrl_next  = s_ctrl_reg;
            s_valid_next = 1'b0;
        end else if (!m_valid_reg || out_fire) begin
            m_valid_next = in_fire;
            if (in_fire) begin
                m_data_next = in_data;
                m_ctrl_next = in_ctrl;
            end
        end else if (in_fire) begin
            s_valid_next = 1'b1;
            s_data_next  = in_data;
            s_ctrl_next  = in_ctrl;
        end

        // An empty stage presents zero data when clearing is enabled.
        if ((CLEAR_DATA != 0) && !m_valid_next) begin
            m_data_next = '0;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_clr) begin
            stall_cnt_next = '0;
        end else if (m_valid_reg && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_reg   <= 1'b0;
            m_data_reg    <= '0;
            m_ctrl_reg    <= '0;
            s_valid_reg   <= 1'b0;
            s_data_reg    <= '0;
            s_ctrl_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            m_valid_reg   <= m_valid_next;
            m_data_reg    <= m_data_next;
            m_ctrl_reg    <= m_ctrl_next;
            s_valid_reg   <= s_valid_next;
            s_data_reg    <= s_data_next;
            s_ctrl_reg    <= s_ctrl_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: two instances share the stimulus, one keeping
// data on empty with a 16-bit counter, one clearing data with a 4-bit counter.
module tb_pipe_stage_reg;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          stall_clr;

    logic          a_in_ready, a_out_valid;
    logic [DW-1:0] a_out_data;
    logic [CW-1:0] a_out_ctrl;
    logic [15:0]   a_stall_cnt;

    logic          b_in_ready, b_out_valid;
    logic [DW-1:0] b_out_data;
    logic [CW-1:0] b_out_ctrl;
    logic [3:0]    b_stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16), .CLEAR_DATA(0)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .stall_cnt(a_stall_cnt), .stall_clr(stall_clr)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4), .CLEAR_DATA(1)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .stall_cnt(b_stall_cnt), .stall_clr(stall_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] stream_vals [3];

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; stall_clr = 1'b0;
        stream_vals[0] = 8'h10; stream_vals[1] = 8'h11; stream_vals[2] = 8'h12;

        #2;
        check("rst_valid", a_out_valid, 0);
        check("rst_ready", a_in_ready, 1);
        check("rst_data",  a_out_data, 0);
        check("rst_ctrl",  a_out_ctrl, 0);
        check("rst_stall", a_stall_cnt, 0);
        tick();
        reset = 1'b0;

        // Streaming at full rate
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = stream_vals[i];
            in_ctrl = stream_vals[i];
            tick();
            check("strm_data",  a_out_data, stream_vals[i]);
            check("strm_valid", a_out_valid, 1);
            check("strm_ready", a_in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        check("strm_empty", a_out_valid, 0);
        check("strm_stall", a_stall_cnt, 0);

        // Backpressure through the skid buffer
        in_valid = 1'b1; in_data = 8'hA0; in_ctrl = 8'h01;
        tick();
        check("bp_a0", a_out_data, 8'hA0);
        out_ready = 1'b0; in_data = 8'hA1; in_ctrl = 8'h02;
        tick();
        check("bp_skid_rdy", a_in_ready, 0);
        check("bp_hold_a0", a_out_data, 8'hA0);
        in_data = 8'hA2; in_ctrl = 8'h03;
        tick();
        check("bp_hold_a0", a_out_data, 8'hA0);
        tick();
        check("bp_hold_a0", a_out_data, 8'hA0);
        check("bp_rdy_low", a_in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("bp_a1", a_out_data, 8'hA1);
        check("bp_a1_ctrl", a_out_ctrl, 8'h02);
        check("bp_rdy_back", a_in_ready, 1);
        tick();
        check("bp_a2", a_out_data, 8'hA2);
        check("bp_a2_valid", a_out_valid, 1);
        in_valid = 1'b0;
        tick();
        check("bp_empty", a_out_valid, 0);
        check("bp_stall", a_stall_cnt, 3);

        // Flush with main and skid both occupied
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC0; in_ctrl = 8'h03;
        tick();
        in_data = 8'hC1; in_ctrl = 8'h04;
        tick();
        check("fl_full", a_in_ready, 0);
        flush = 1'b1; in_data = 8'hBB; in_ctrl = 8'hFF;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", a_out_valid, 0);
        check("fl_ctrl", a_out_ctrl, 0);
        check("fl_ready", a_in_ready, 1);
        check("fl_data_hold", a_out_data, 8'hC0);
        check("fl_data_clr", b_out_data, 0);
        check("fl_stall_kept", a_stall_cnt, 5);
        out_ready = 1'b1;
        tick();
        check("fl_no_bb", a_out_valid, 0);
        tick();
        check("fl_no_bb", a_out_valid, 0);

        // Bubble masking of control and optional data clearing
        in_valid = 1'b1; in_data = 8'h77; in_ctrl = 8'h5A;
        tick();
        check("bub_ctrl", a_out_ctrl, 8'h5A);
        check("bub_data_b", b_out_data, 8'h77);
        in_valid = 1'b0;
        tick();
        check("bub_valid", a_out_valid, 0);
        check("bub_ctrl0", a_out_ctrl, 0);
        check("bub_ctrl0_b", b_out_ctrl, 0);
        check("bub_data_a", a_out_data, 8'h77);
        check("bub_data_b0", b_out_data, 0);

        // Stall counter saturation and clear priority
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        check("sat_clr0", b_stall_cnt, 0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h33; in_ctrl = 8'h06;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_b", b_stall_cnt, 15);
        check("sat_a", a_stall_cnt, 20);
        stall_clr = 1'b1;
        tick();
        check("sat_clr", b_stall_cnt, 0);
        stall_clr = 1'b0;
        tick();
        check("sat_resume", b_stall_cnt, 1);

        // Asynchronous reset while full
        in_valid = 1'b1; in_data = 8'h44; in_ctrl = 8'h07;
        tick();
        in_valid = 1'b0;
        check("ar_full", a_in_ready, 0);
        #3 reset = 1'b1;
        #1;
        check("ar_valid", a_out_valid, 0);
        check("ar_ready", a_in_ready, 1);
        check("ar_ctrl", a_out_ctrl, 0);
        check("ar_stall", a_stall_cnt, 0);
        #1 reset = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_ctrl = 8'h09;
        tick();
        check("ar_first", a_out_data, 8'h55);
        check("ar_first_v", a_out_valid, 1);
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
